eth_rx_unwrap: RTL
==================

Name: eth_rx_unwrap

Overview:
Receive-side counterpart of the transmit header builder. Accepts the dibit stream of one Ethernet frame (preamble/SFD already removed), parses destination address, source address and ethertype MSB-first, and filters on destination and ethertype. For accepted frames it forwards only the payload dibits. It sits between the RMII receive/deframing logic and the application payload consumer.

Parameters:
MY_ADDR, 48'h69695A065491, unicast destination address accepted by this node
ACCEPT_BCAST, 1'b1, also accept destination 48'hFFFFFFFFFFFF
ETHERTYPE, 16'h0101, required ethertype
CHECK_ETHERTYPE, 1'b1, 0 = accept any ethertype

Ports:
clk  in  1  50 MHz system clock
rst  in  1  system reset
axiiv  in  1  input dibit valid; high for the whole frame, no gaps
axiid  in  2  input dibit, MSB-first within each header field
axiov  out  1  payload dibit valid
axiod  out  2  payload dibit
frame_src  out  48  source address of the last accepted frame
frame_done  out  1  one-cycle pulse: accepted frame ended
payload_len  out  16  payload dibit count, updated together with frame_done
frame_drop  out  1  one-cycle pulse: frame rejected
drop_reason  out  2  1 = dest mismatch, 2 = ethertype mismatch, 3 = runt; valid with frame_drop

Interface decision: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- All outputs are registered. Reset values: axiov=0, axiod=0, frame_src=0, frame_done=0, payload_len=0, frame_drop=0, drop_reason=0. Reset state is DRAIN, with header index and payload counter at 0.
- States:
  - DRAIN: wait for axiiv=0, then go to IDLE. Produces no pulses.
  - IDLE: axiiv=1 captures header dibit 0 into the shift register, sets idx=1 and goes to HDR.
  - HDR: on each axiiv=1 cycle, shift in a dibit and increment idx. Dibits 0-23 are dest, 24-47 are source, 48-55 are ethertype.
  - PAYLOAD: forwards payload dibits.
  - Leaving DRAIN by reset therefore ignores any frame already in flight when reset is released.
- Header checks, each made on the same cycle the named dibit arrives, using {sr, axiid}:
  - idx 23, destination check. Accept if the value equals MY_ADDR, or if ACCEPT_BCAST=1 and it is all ones. Otherwise pulse frame_drop (next cycle) with reason 1 and go to DRAIN.
  - idx 47, source capture. The value goes to an internal pending_src register. frame_src updates only at frame_done.
  - idx 55, ethertype check. If CHECK_ETHERTYPE=1 and the value differs from ETHERTYPE, pulse frame_drop with reason 2 and go to DRAIN. Otherwise go to PAYLOAD and clear the payload counter.
- Runt: axiiv=0 in HDR at any idx gives frame_drop with reason 3, then IDLE. No axiov is produced for a runt.
- PAYLOAD with axiiv=1: axiov<=1, axiod<=axiid (1-cycle latency), counter+1. The counter saturates at 16'hFFFF.
- PAYLOAD with axiiv=0: axiov<=0, frame_done<=1, payload_len<=counter, frame_src<=pending_src, then IDLE.
  - A zero-length payload still produces frame_done with payload_len=0.
- axiod holds its last value when axiov=0. frame_done and frame_drop never assert together and each lasts exactly 1 cycle.
- A new frame is accepted from IDLE on the cycle after frame_done or after a runt drop. A single idle cycle between frames is enough.

Decomposition:
- Shared package eth_pkg holds:
  - header field lengths in dibits: DEST 24, SRC 24, TYPE 8, HDR 56
  - broadcast address constant
  - default node addresses 69:69:5A:06:54:90 and :91
  - default ethertype 16'h0101
  - a drop_reason enum (NONE, DEST, TYPE, RUNT)
- The same package is shared with the transmit header builder.
- No sub-module: this is a single FSM with a 48-bit shift register and one counter.

Test Plan:
1. Broadcast dest, src 69695A065490, type 0101, payload dibits 3,0,2,1, then axiiv=0 -> axiov high 4 cycles with axiod 3,0,2,1, each 1 cycle after input; then frame_done=1, payload_len=4, frame_src=69695A065490.
2. Dest 69695A065492 -> frame_drop with reason 1 on the cycle after dibit 23; axiov stays 0; next frame with dest=MY_ADDR is accepted.
3. Type 0800 with valid dest -> frame_drop with reason 2 after dibit 55; no axiov; frame_src unchanged from the previous frame.
4. axiiv drops after 30 dibits -> frame_drop with reason 3; header of exactly 56 dibits then drop -> frame_done with payload_len=0.
5. Assert rst mid-payload; axiiv stays high 20 more cycles -> outputs at reset values and no pulses; after axiiv=0 for 1 cycle, a valid frame is accepted normally.
6. Two valid frames separated by one idle cycle -> two frame_done pulses with the correct payload_len for each; no dibit from frame 1 appears in frame 2.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet header definitions used by the transmit header builder
// and the receive-side header unwrapper.
package eth_pkg;

  // Header field lengths, counted in RMII dibits
  localparam int DEST_DIBITS = 24;
  localparam int SRC_DIBITS  = 24;
  localparam int TYPE_DIBITS = 8;
  localparam int HDR_DIBITS  = DEST_DIBITS + SRC_DIBITS + TYPE_DIBITS;

  // Index of the last dibit of each header field
  localparam int DEST_LAST = DEST_DIBITS - 1;
  localparam int SRC_LAST  = DEST_DIBITS + SRC_DIBITS - 1;
  localparam int TYPE_LAST = HDR_DIBITS - 1;

  localparam logic [47:0] BCAST_ADDR        = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] NODE_ADDR_0       = 48'h6969_5A06_5490;
  localparam logic [47:0] NODE_ADDR_1       = 48'h6969_5A06_5491;
  localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h0101;

  typedef enum logic [1:0] {
    DROP_NONE = 2'd0,
    DROP_DEST = 2'd1,
    DROP_TYPE = 2'd2,
    DROP_RUNT = 2'd3
  } drop_reason_t;

  typedef enum logic [1:0] {
    RX_DRAIN   = 2'd0,
    RX_IDLE    = 2'd1,
    RX_HDR     = 2'd2,
    RX_PAYLOAD = 2'd3
  } rx_state_t;

endpackage

// File: rtl/eth_rx_unwrap.sv
// Receive header unwrapper: parses dest/src/ethertype from the dibit
// stream, filters the frame and forwards only payload dibits.
module eth_rx_unwrap
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_ADDR         = NODE_ADDR_1,
  parameter logic        ACCEPT_BCAST    = 1'b1,
  parameter logic [15:0] ETHERTYPE       = DEFAULT_ETHERTYPE,
  parameter logic        CHECK_ETHERTYPE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic [47:0] frame_src,
  output logic        frame_done,
  output logic [15:0] payload_len,
  output logic        frame_drop,
  output logic [1:0]  drop_reason
);

  rx_state_t   state_reg, state_next;
  logic [5:0]  idx_reg, idx_next;
  logic [47:0] sr_reg, sr_next;
  logic [47:0] pending_src_reg, pending_src_next;
  logic [15:0] cnt_reg, cnt_next;

  logic        axiov_next;
  logic [1:0]  axiod_next;
  logic [47:0] frame_src_next;
  logic        frame_done_next;
  logic [15:0] payload_len_next;
  logic        frame_drop_next;
  logic [1:0]  drop_reason_next;

  // The field that ends on the current dibit is always the low bits of
  // {sr, axiid}; older bits in the shift register are don't-care.
  logic [47:0] hdr_word;
  logic        at_dest_last, at_src_last, at_type_last;
  logic        dest_ok, type_ok;

  assign hdr_word     = {sr_reg[45:0], axiid};
  assign at_dest_last = (idx_reg == 6'(DEST_LAST));
  assign at_src_last  = (idx_reg == 6'(SRC_LAST));
  assign at_type_last = (idx_reg == 6'(TYPE_LAST));
  assign dest_ok      = (hdr_word == MY_ADDR) ||
                        (ACCEPT_BCAST && (hdr_word == BCAST_ADDR));
  assign type_ok      = !CHECK_ETHERTYPE || (hdr_word[15:0] == ETHERTYPE);

  // State register; reset lands in DRAIN so a frame in flight is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RX_DRAIN;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_DRAIN:   if (!axiiv) state_next = RX_IDLE;
      RX_IDLE:    if (axiiv)  state_next = RX_HDR;
      RX_HDR: begin
        if (!axiiv)                        state_next = RX_IDLE;
        else if (at_dest_last && !dest_ok) state_next = RX_DRAIN;
        else if (at_type_last)             state_next = type_ok ? RX_PAYLOAD : RX_DRAIN;
      end
      RX_PAYLOAD: if (!axiiv) state_next = RX_IDLE;
      default:    state_next = RX_DRAIN;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    idx_next         = idx_reg;
    sr_next          = sr_reg;
    pending_src_next = pending_src_reg;
    cnt_next         = cnt_reg;
    axiov_next       = 1'b0;
    axiod_next       = axiod;
    frame_src_next   = frame_src;
    frame_done_next  = 1'b0;
    payload_len_next = payload_len;
    frame_drop_next  = 1'b0;
    drop_reason_next = drop_reason;
    case (state_reg)
      RX_IDLE: begin
        if (axiiv) begin
          sr_next  = hdr_word;
          idx_next = 6'd1;
        end
      end
      RX_HDR: begin
        if (axiiv) begin
          sr_next  = hdr_word;
          idx_next = idx_reg + 6'd1;
          if (at_dest_last && !dest_ok) begin
            frame_drop_next  = 1'b1;
            drop_reason_next = DROP_DEST;
          end
          if (at_src_last) pending_src_next = hdr_word;
          if (at_type_last) begin
            if (!type_ok) begin
              frame_drop_next  = 1'b1;
              drop_reason_next = DROP_TYPE;
            end else begin
              cnt_next = 16'd0;
            end
          end
        end else begin
          frame_drop_next  = 1'b1;
          drop_reason_next = DROP_RUNT;
        end
      end
      RX_PAYLOAD: begin
        if (axiiv) begin
          axiov_next = 1'b1;
          axiod_next = axiid;
          cnt_next   = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
        end else begin
          frame_done_next  = 1'b1;
          payload_len_next = cnt_reg;
          frame_src_next   = pending_src_reg;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg         <= '0;
      sr_reg          <= '0;
      pending_src_reg <= '0;
      cnt_reg         <= '0;
      axiov           <= 1'b0;
      axiod           <= '0;
      frame_src       <= '0;
      frame_done      <= 1'b0;
      payload_len     <= '0;
      frame_drop      <= 1'b0;
      drop_reason     <= DROP_NONE;
    end else begin
      idx_reg         <= idx_next;
      sr_reg          <= sr_next;
      pending_src_reg <= pending_src_next;
      cnt_reg         <= cnt_next;
      axiov           <= axiov_next;
      axiod           <= axiod_next;
      frame_src       <= frame_src_next;
      frame_done      <= frame_done_next;
      payload_len     <= payload_len_next;
      frame_drop      <= frame_drop_next;
      drop_reason     <= drop_reason_next;
    end
  end

endmodule
